st_video_fetch: RTL and testbench

- MMU-side video DMA engine; the transmitting end of the shifter LOAD/data interface.
- While display enable is active, fetches screen words from RAM through a video address counter.
- Presents each word on the shifter data bus with a LOAD strobe, always in groups of 4 words (one 16-pixel block).
- Counter reloads from the CPU-programmed video base at every vsync.

---
 rtl/st_video_fetch.sv | 209 ++++++++++++++++++++
 tb/tb_st_video_fetch.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/st_video_fetch.sv
// rtl/st_video_fetch.sv - video DMA fetch engine driving the shifter LOAD/data interface
module st_video_fetch #(
  parameter int SLOT_CYCLES     = 16,
  parameter int LOAD_LOW_CYCLES = 4
) (
  input  logic        CLOCK_32,
  input  logic        reset,
  input  logic        de,
  input  logic        vsync,
  input  logic        cpu_we,
  input  logic        cpu_sel,
  input  logic [7:0]  cpu_wdata,
  output logic        ram_req,
  output logic [22:0] ram_addr,
  input  logic        ram_ack,
  input  logic [15:0] ram_data,
  output logic        load_n,
  output logic [15:0] shifter_data,
  output logic        shifter_cs,
  output logic [22:0] vcount,
  output logic        overrun
);

  localparam int SW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int LW = $clog2(LOAD_LOW_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic            de_m;
  logic            de_s;
  logic            de_d;
  logic            vs_m;
  logic            vs_s;
  logic            vs_d;
  logic            de_rise;
  logic            vs_edge;

  logic [SW-1:0]   slot;
  logic            slot_zero;

  logic [7:0]      base_hi;
  logic [7:0]      base_mid;
  logic [22:0]     base_word;

  logic [1:0]      word_idx;
  logic [LW-1:0]   low_cnt;

  logic            start_fetch;
  logic            take_ack;
  logic            low_done;

  // The shifter chip select is never driven active by the fetch engine.
  assign shifter_cs = 1'b1;

  assign de_rise   = de_s & ~de_d;
  assign vs_edge   = vs_s & ~vs_d;
  assign slot_zero = (slot == '0);
  assign base_word = {base_hi, base_mid, 7'b0};

  // Two-flop synchronisers for the GLUE timing inputs, plus one delay stage for edge detection.
  always_ff @(posedge CLOCK_32 or posedge reset) begin
    if (reset) begin
      de_m <= 1'b0;
      de_s <= 1'b0;
      de_d <= 1'b0;
      vs_m <= 1'b0;
      vs_s <= 1'b0;
      vs_d <= 1'b0;
    end else begin
      de_m <= de;
      de_s <= de_m;
      de_d <= de_s;
      vs_m <= vsync;
      vs_s <= vs_m;
      vs_d <= vs_s;
    end
  end

  // Free-running fetch slot counter, realigned when display enable rises.
  always_ff @(posedge CLOCK_32 or posedge reset) begin
    if (reset) begin
      slot <= '0;
    end else if (de_rise) begin
      slot <= '0;
    end else if (slot == SW'(SLOT_CYCLES - 1)) begin
      slot <= '0;
    end else begin
      slot <= slot + 1'b1;
    end
  end

  // CPU-programmed video base; only the next vsync moves it into the counter.
  always_ff @(posedge CLOCK_32 or posedge reset) begin
    if (reset) begin
      base_hi  <= 8'h00;
      base_mid <= 8'h00;
    end else if (cpu_we) begin
      if (cpu_sel) begin
        base_mid <= cpu_wdata;
      end else begin
        base_hi  <= cpu_wdata;
      end
    end
  end

  // Fetch FSM state register.
  always_ff @(posedge CLOCK_32 or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Fetch FSM next state: a fetch starts only on slot 0, and an unfinished group keeps fetching.
  always_comb begin
    state_nxt   = state;
    start_fetch = 1'b0;
    take_ack    = 1'b0;
    low_done    = 1'b0;
    case (state)
      IDLE: begin
        if (slot_zero && (de_s || (word_idx != 2'd0))) begin
          start_fetch = 1'b1;
          state_nxt   = REQ;
        end
      end
      REQ: begin
        if (ram_ack) begin
          take_ack  = 1'b1;
          state_nxt = LOW;
        end
      end
      LOW: begin
        if (low_cnt == LW'(LOAD_LOW_CYCLES - 1)) begin
          low_done  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // RAM request: address is latched at fetch start and held until the acknowledge.
  always_ff @(posedge CLOCK_32 or posedge reset) begin
    if (reset) begin
      ram_req  <= 1'b0;
      ram_addr <= 23'd0;
    end else if (start_fetch) begin
      ram_req  <= 1'b1;
      ram_addr <= vcount;
    end else if (take_ack) begin
      ram_req  <= 1'b0;
    end
  end

  // Shifter side: capture the word on acknowledge and hold LOAD low for a fixed pulse width.
  always_ff @(posedge CLOCK_32 or posedge reset) begin
    if (reset) begin
      shifter_data <= 16'h0000;
      load_n       <= 1'b1;
      low_cnt      <= '0;
    end else if (take_ack) begin
      shifter_data <= ram_data;
      load_n       <= 1'b0;
      low_cnt      <= '0;
    end else if (state == LOW) begin
      low_cnt <= low_cnt + 1'b1;
      if (low_done) begin
        load_n <= 1'b1;
      end
    end
  end

  // Video address counter and group position; a vsync reload takes priority over an increment.
  always_ff @(posedge CLOCK_32 or posedge reset) begin
    if (reset) begin
      vcount   <= 23'd0;
      word_idx <= 2'd0;
    end else if (vs_edge) begin
      vcount   <= base_word;
      word_idx <= 2'd0;
    end else if (take_ack) begin
      vcount   <= vcount + 23'd1;
      word_idx <= word_idx + 2'd1;
    end
  end

  // Sticky overrun: a slot boundary arrived while a fetch was still in flight.
  always_ff @(posedge CLOCK_32 or posedge reset) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (vs_edge) begin
      overrun <= 1'b0;
    end else if (slot_zero && (state != IDLE)) begin
      overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_st_video_fetch.sv
// tb/tb_st_video_fetch.sv - randomized self-checking bench for st_video_fetch
module tb_st_video_fetch;

  logic        CLOCK_32;
  logic        reset;
  logic        de;
  logic        vsync;
  logic        cpu_we;
  logic        cpu_sel;
  logic [7:0]  cpu_wdata;
  logic        ram_req;
  logic [22:0] ram_addr;
  logic        ram_ack;
  logic [15:0] ram_data;
  logic        load_n;
  logic [15:0] shifter_data;
  logic        shifter_cs;
  logic [22:0] vcount;
  logic        overrun;

  int          vectors;
  int          miscompares;
  int          cyc;

  // reference model state
  logic [7:0]  m_hi;
  logic [7:0]  m_mid;
  logic [22:0] exp_base;
  logic [22:0] exp_vcount;
  logic [15:0] exp_data[$];
  int          falls[$];

  // RAM responder control
  bit          auto_ack;
  int          ack_delay;
  int          req_cnt;

  // LOAD monitor state
  bit          in_low;
  int          low_len;

  st_video_fetch #(.SLOT_CYCLES(16), .LOAD_LOW_CYCLES(4)) dut (
    .CLOCK_32     (CLOCK_32),
    .reset        (reset),
    .de           (de),
    .vsync        (vsync),
    .cpu_we       (cpu_we),
    .cpu_sel      (cpu_sel),
    .cpu_wdata    (cpu_wdata),
    .ram_req      (ram_req),
    .ram_addr     (ram_addr),
    .ram_ack      (ram_ack),
    .ram_data     (ram_data),
    .load_n       (load_n),
    .shifter_data (shifter_data),
    .shifter_cs   (shifter_cs),
    .vcount       (vcount),
    .overrun      (overrun)
  );

  initial begin
    CLOCK_32 = 1'b0;
    forever #5 CLOCK_32 = ~CLOCK_32;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge CLOCK_32);
      cyc++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // RAM model: acknowledges each request after ack_delay sampled cycles with random data.
  initial begin
    req_cnt = 0;
    forever begin
      @(negedge CLOCK_32);
      if (auto_ack) begin
        ram_ack = 1'b0;
        if (ram_req && !reset) begin
          req_cnt++;
          if (req_cnt >= ack_delay) begin
            ram_data = 16'($urandom);
            ram_ack  = 1'b1;
            chk("ram_addr", 32'(ram_addr), 32'(exp_vcount));
            exp_data.push_back(ram_data);
            exp_vcount = exp_vcount + 23'd1;
            req_cnt = 0;
          end
        end else begin
          req_cnt = 0;
        end
      end
    end
  end

  // LOAD monitor: every low pulse carries the next acknowledged word and lasts 4 cycles.
  initial begin
    in_low  = 1'b0;
    low_len = 0;
    forever begin
      @(negedge CLOCK_32);
      if (reset) begin
        in_low  = 1'b0;
        low_len = 0;
      end else if (!load_n) begin
        if (!in_low) begin
          in_low  = 1'b1;
          low_len = 1;
          falls.push_back(cyc);
          if (exp_data.size() == 0) begin
            chk("unexpected_load", 32'd1, 32'd0);
          end else begin
            chk("shifter_data", 32'(shifter_data), 32'(exp_data.pop_front()));
          end
          chk("vcount_at_load", 32'(vcount), 32'(exp_vcount));
        end else begin
          low_len++;
        end
      end else if (in_low) begin
        in_low = 1'b0;
        chk("load_low_len", 32'(low_len), 32'd4);
      end
    end
  end

  task automatic cpu_write(input logic sel, input logic [7:0] val);
    @(negedge CLOCK_32);
    cpu_we    = 1'b1;
    cpu_sel   = sel;
    cpu_wdata = val;
    @(negedge CLOCK_32);
    cpu_we    = 1'b0;
    if (sel) m_mid = val;
    else     m_hi  = val;
    exp_base = {m_hi, m_mid, 7'b0};
  endtask

  task automatic vsync_pulse();
    @(negedge CLOCK_32);
    vsync = 1'b1;
    repeat (4) @(negedge CLOCK_32);
    vsync = 1'b0;
    repeat (4) @(negedge CLOCK_32);
    exp_vcount = exp_base;
    chk("vsync_vcount", 32'(vcount), 32'(exp_base));
    chk("vsync_overrun", 32'(overrun), 32'd0);
  endtask

  task automatic wait_falls(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (falls.size() >= n) break;
      @(negedge CLOCK_32);
    end
    chk("wait_falls", 32'(falls.size() >= n), 32'd1);
  endtask

  task automatic wait_req(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge CLOCK_32);
      if (ram_req) break;
    end
    chk("wait_req", 32'(ram_req), 32'd1);
  endtask

  initial begin
    int          n;
    int          loads;
    logic [15:0] d;

    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    de          = 1'b0;
    vsync       = 1'b0;
    cpu_we      = 1'b0;
    cpu_sel     = 1'b0;
    cpu_wdata   = 8'h00;
    ram_ack     = 1'b0;
    ram_data    = 16'h0000;
    auto_ack    = 1'b1;
    ack_delay   = 2;
    m_hi        = 8'h00;
    m_mid       = 8'h00;
    exp_base    = 23'd0;
    exp_vcount  = 23'd0;

    // reset state
    repeat (3) @(negedge CLOCK_32);
    chk("rst_load_n", 32'(load_n), 32'd1);
    chk("rst_shifter_data", 32'(shifter_data), 32'd0);
    chk("rst_shifter_cs", 32'(shifter_cs), 32'd1);
    chk("rst_ram_req", 32'(ram_req), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_vcount", 32'(vcount), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge CLOCK_32);

    // base programming: write does not touch vcount, vsync loads it
    cpu_write(1'b0, 8'h07);
    cpu_write(1'b1, 8'h80);
    repeat (3) @(negedge CLOCK_32);
    chk("write_no_reload", 32'(vcount), 32'd0);
    vsync_pulse();
    chk("base_0x03C000", 32'(vcount), 32'h03C000);
    chk("idle_load_n", 32'(load_n), 32'd1);

    // steady fetch: two full groups, one load every 16 cycles
    ack_delay = 2;
    falls.delete();
    de = 1'b1;
    wait_falls(4, 200);
    chk("vcount_after_group", 32'(vcount), 32'h03C004);
    wait_falls(8, 200);
    de = 1'b0;
    for (int i = 1; i < falls.size(); i++) begin
      chk("load_period", 32'(falls[i] - falls[i-1]), 32'd16);
    end
    repeat (60) @(negedge CLOCK_32);
    chk("steady_loads", 32'(falls.size()), 32'd8);
    chk("steady_req_idle", 32'(ram_req), 32'd0);
    chk("steady_vcount", 32'(vcount), 32'h03C008);

    // directed group completion: de falls after the 2nd word
    falls.delete();
    de = 1'b1;
    wait_falls(2, 200);
    de = 1'b0;
    repeat (100) @(negedge CLOCK_32);
    chk("group2_loads", 32'(falls.size()), 32'd4);
    chk("group2_req_idle", 32'(ram_req), 32'd0);
    chk("group2_vcount", 32'(vcount), 32'(exp_base + 23'd12));

    // randomized bases, latencies and de drop points: loads round up to whole groups
    for (int r = 0; r < 4; r++) begin
      cpu_write(1'b0, 8'($urandom));
      cpu_write(1'b1, 8'($urandom));
      vsync_pulse();
      ack_delay = $urandom_range(1, 5);
      n = $urandom_range(1, 7);
      loads = ((n + 3) / 4) * 4;
      falls.delete();
      de = 1'b1;
      wait_falls(n, 400);
      de = 1'b0;
      repeat (120) @(negedge CLOCK_32);
      chk("rand_loads", 32'(falls.size()), 32'(loads));
      chk("rand_req_idle", 32'(ram_req), 32'd0);
      chk("rand_vcount", 32'(vcount), 32'(exp_base + 23'(loads)));
      chk("rand_overrun", 32'(overrun), 32'd0);
    end

    // overrun: acknowledge withheld 20 cycles
    ack_delay = 20;
    falls.delete();
    de = 1'b1;
    wait_req(100);
    repeat (17) @(negedge CLOCK_32);
    chk("overrun_set", 32'(overrun), 32'd1);
    chk("overrun_req_held", 32'(ram_req), 32'd1);
    chk("overrun_addr_held", 32'(ram_addr), 32'(exp_vcount));
    wait_falls(1, 40);
    ack_delay = 2;
    wait_falls(4, 200);
    de = 1'b0;
    repeat (80) @(negedge CLOCK_32);
    chk("overrun_loads", 32'(falls.size()), 32'd4);
    chk("overrun_sticky", 32'(overrun), 32'd1);
    vsync_pulse();

    // vsync edge coincident with the acknowledge: reload wins over the increment
    cpu_write(1'b0, 8'($urandom));
    cpu_write(1'b1, 8'($urandom));
    auto_ack = 1'b0;
    ram_ack  = 1'b0;
    falls.delete();
    de = 1'b1;
    wait_req(100);
    de = 1'b0;
    chk("coinc_addr", 32'(ram_addr), 32'(exp_vcount));
    vsync = 1'b1;
    @(negedge CLOCK_32);
    @(negedge CLOCK_32);
    d = 16'($urandom);
    ram_data = d;
    ram_ack  = 1'b1;
    exp_data.push_back(d);
    exp_vcount = exp_base;
    @(negedge CLOCK_32);
    ram_ack = 1'b0;
    repeat (6) @(negedge CLOCK_32);
    chk("coinc_vcount", 32'(vcount), 32'(exp_base));
    chk("coinc_loads", 32'(falls.size()), 32'd1);
    chk("coinc_shifter_data", 32'(shifter_data), 32'(d));
    vsync = 1'b0;
    auto_ack = 1'b1;
    repeat (4) @(negedge CLOCK_32);

    // asynchronous reset while LOAD is low
    ack_delay = 2;
    de = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLOCK_32);
      if (!load_n) break;
    end
    chk("pre_reset_low", 32'(load_n), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("async_load_n", 32'(load_n), 32'd1);
    chk("async_ram_req", 32'(ram_req), 32'd0);
    chk("async_vcount", 32'(vcount), 32'd0);
    chk("async_ram_addr", 32'(ram_addr), 32'd0);
    chk("async_shifter_data", 32'(shifter_data), 32'd0);
    chk("async_overrun", 32'(overrun), 32'd0);
    de = 1'b0;
    exp_data.delete();
    m_hi       = 8'h00;
    m_mid      = 8'h00;
    exp_base   = 23'd0;
    exp_vcount = 23'd0;
    repeat (3) @(negedge CLOCK_32);
    reset = 1'b0;
    repeat (2) @(negedge CLOCK_32);
    // base was cleared, so a vsync reloads zero
    vsync_pulse();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=%0d expected=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
